// File: rtl/rad_meas_sequencer_if.sv
// Host-side handshake and result bus of the GM measurement sequencer.
// The host (master) requests and acknowledges; the sequencer (slave) reports status and result.
interface rad_meas_sequencer_if #(
  parameter int unsigned CNT_W = 6
) ();
  logic             START;
  logic             ABORT;
  logic             ACK;
  logic             BUSY;
  logic             VALID;
  logic             FAULT;
  logic [CNT_W-1:0] COUNT;
  logic             OVF;
  logic             LOWV;

  modport master (
    output START, ABORT, ACK,
    input  BUSY, VALID, FAULT, COUNT, OVF, LOWV
  );

  modport slave (
    input  START, ABORT, ACK,
    output BUSY, VALID, FAULT, COUNT, OVF, LOWV
  );
endinterface

// File: rtl/rad_meas_sequencer.sv
// Geiger-Mueller measurement sequencer: charges tube HV, settles, counts ticks over a fixed
// gate window, then holds the result until the host acknowledges it.
module rad_meas_sequencer #(
  parameter int unsigned CNT_W          = 6,
  parameter int unsigned TMR_W          = 24,
  parameter int unsigned CHARGE_TIMEOUT = 65535,
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned GATE_CYCLES    = 1000000
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  TICK,
  input  logic                  nCHARGED,
  output logic                  OSCOUT,
  rad_meas_sequencer_if.slave   bus
);

  localparam logic [TMR_W-1:0] CHARGE_LAST = TMR_W'(CHARGE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StCharge,
    StSettle,
    StGate,
    StHold,
    StFault
  } state_e;

  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic             tick_meta_q, tick_s_q, tick_prev_q;
  logic             ncharged_meta_q, ncharged_s_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             lowv_q;
  logic             tick_evt;
  logic             active;

  assign tick_evt = tick_s_q & ~tick_prev_q;
  assign active   = (state_q == StCharge) || (state_q == StSettle) || (state_q == StGate);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q         <= StIdle;
      timer_q         <= '0;
      tick_meta_q     <= 1'b0;
      tick_s_q        <= 1'b0;
      tick_prev_q     <= 1'b0;
      ncharged_meta_q <= 1'b0;
      ncharged_s_q    <= 1'b0;
      count_q         <= '0;
      ovf_q           <= 1'b0;
      lowv_q          <= 1'b0;
    end else begin
      tick_meta_q     <= TICK;
      tick_s_q        <= tick_meta_q;
      tick_prev_q     <= tick_s_q;
      ncharged_meta_q <= nCHARGED;
      ncharged_s_q    <= ncharged_meta_q;

      // Abort leaves the last result registers untouched.
      if (bus.ABORT && (state_q != StIdle)) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.START) begin
              state_q <= StCharge;
              timer_q <= '0;
            end
          end
          StCharge: begin
            if (!ncharged_s_q) begin
              state_q <= StSettle;
              timer_q <= '0;
            end else if (timer_q == CHARGE_LAST) begin
              state_q <= StFault;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          StSettle: begin
            if (timer_q == SETTLE_LAST) begin
              state_q <= StGate;
              timer_q <= '0;
              count_q <= '0;
              ovf_q   <= 1'b0;
              lowv_q  <= 1'b0;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          StGate: begin
            if (tick_evt) begin
              if (count_q != COUNT_MAX) begin
                count_q <= count_q + CNT_W'(1);
              end else begin
                ovf_q <= 1'b1;
              end
            end
            if (ncharged_s_q) begin
              lowv_q <= 1'b1;
            end
            if (timer_q == GATE_LAST) begin
              state_q <= StHold;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          StHold, StFault: begin
            if (bus.ACK) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Oscillator regulates HV in every active phase; reset clears it without a clock.
  assign OSCOUT    = active & ncharged_s_q;
  assign bus.BUSY  = active;
  assign bus.VALID = (state_q == StHold);
  assign bus.FAULT = (state_q == StFault);
  assign bus.COUNT = count_q;
  assign bus.OVF   = ovf_q;
  assign bus.LOWV  = lowv_q;

endmodule

// File: tb/tb_rad_meas_sequencer.sv
// Self-checking bench for rad_meas_sequencer: phase-countdown reference model compared every
// cycle, directed scenarios with literal expectations, then a randomized stretch.
module tb_rad_meas_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = 8;
  localparam int unsigned CT    = 16;
  localparam int unsigned SC    = 4;
  localparam int unsigned GC    = 100;
  localparam int          CMAX  = 15;

  localparam int M_IDLE = 0, M_CHARGE = 1, M_SETTLE = 2, M_GATE = 3, M_HOLD = 4, M_FAULT = 5;

  logic CLK = 1'b0;
  logic nRESET;
  logic TICK;
  logic nCHARGED;
  logic OSCOUT;

  rad_meas_sequencer_if #(.CNT_W(CNT_W)) bus ();

  rad_meas_sequencer #(
    .CNT_W         (CNT_W),
    .TMR_W         (TMR_W),
    .CHARGE_TIMEOUT(CT),
    .SETTLE_CYCLES (SC),
    .GATE_CYCLES   (GC)
  ) dut (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .TICK    (TICK),
    .nCHARGED(nCHARGED),
    .OSCOUT  (OSCOUT),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int osc_cnt = 0;
  bit chk_en = 0;

  // Reference model: phase plus cycles remaining in it, and pin history for the synchronisers.
  int ph = M_IDLE;
  int left = 0;
  int m_count = 0;
  bit m_ovf = 0, m_lowv = 0;
  bit tp1 = 0, tp2 = 0, tp3 = 0, nc1 = 0, nc2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    bit evt;
    @(posedge CLK or negedge nRESET);
    if (!nRESET) begin
      ph = M_IDLE; left = 0; m_count = 0; m_ovf = 0; m_lowv = 0;
      tp1 = 0; tp2 = 0; tp3 = 0; nc1 = 0; nc2 = 0;
    end else begin
      evt = tp2 && !tp3;
      if (ph != M_IDLE && bus.ABORT) ph = M_IDLE;
      else case (ph)
        M_IDLE:   if (bus.START) begin ph = M_CHARGE; left = CT; end
        M_CHARGE: begin
          if (!nc2) begin ph = M_SETTLE; left = SC; end
          else if (left == 1) ph = M_FAULT;
          else left--;
        end
        M_SETTLE: begin
          if (left == 1) begin
            ph = M_GATE; left = GC; m_count = 0; m_ovf = 0; m_lowv = 0;
          end else left--;
        end
        M_GATE: begin
          if (evt) begin
            if (m_count < CMAX) m_count++;
            else m_ovf = 1;
          end
          if (nc2) m_lowv = 1;
          if (left == 1) ph = M_HOLD;
          else left--;
        end
        default: if (bus.ACK) ph = M_IDLE;
      endcase
      tp3 = tp2; tp2 = tp1; tp1 = TICK;
      nc2 = nc1; nc1 = nCHARGED;
    end
  end

  initial forever begin
    bit busy;
    @(negedge CLK);
    if (OSCOUT) osc_cnt++;
    if (chk_en) begin
      busy = (ph == M_CHARGE) || (ph == M_SETTLE) || (ph == M_GATE);
      chk("oscout", {31'd0, OSCOUT}, {31'd0, busy && nc2});
      chk("busy", {31'd0, bus.BUSY}, {31'd0, busy});
      chk("valid", {31'd0, bus.VALID}, {31'd0, ph == M_HOLD});
      chk("fault", {31'd0, bus.FAULT}, {31'd0, ph == M_FAULT});
      chk("count", {28'd0, bus.COUNT}, m_count);
      chk("ovf", {31'd0, bus.OVF}, {31'd0, m_ovf});
      chk("lowv", {31'd0, bus.LOWV}, {31'd0, m_lowv});
    end
  end

  task automatic wait_rel(input int r);
    while (cyc - t0 < r) @(negedge CLK);
  endtask

  task automatic start_run();
    nCHARGED = 1'b1;
    repeat (4) @(negedge CLK);
    osc_cnt = 0;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      TICK = 1'b1;
      repeat (2) @(negedge CLK);
      TICK = 1'b0;
      repeat (2) @(negedge CLK);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(bus.VALID || bus.FAULT) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("done_wait", {31'd0, bus.VALID | bus.FAULT}, 32'd1);
  endtask

  task automatic measure(input int n_ticks, input bit droop);
    start_run();
    fork
      begin
        wait_rel(4);
        nCHARGED = 1'b0;
        if (droop) begin
          wait_rel(50);
          nCHARGED = 1'b1;
          repeat (3) @(negedge CLK);
          nCHARGED = 1'b0;
        end
      end
      begin
        wait_rel(15);
        send_ticks(n_ticks);
      end
    join
    wait_done();
  endtask

  task automatic ack();
    bus.ACK = 1'b1;
    @(negedge CLK);
    bus.ACK = 1'b0;
  endtask

  initial begin
    nRESET = 1'b0;
    TICK = 1'b0;
    nCHARGED = 1'b1;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.ACK = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      TICK = ~TICK;
    end
    @(negedge CLK);
    TICK = 1'b0;
    nRESET = 1'b1;
    chk_en = 1'b1;

    // Idle after reset: everything low for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      chk("rst_idle", {25'd0, OSCOUT, bus.BUSY, bus.VALID, bus.FAULT, bus.COUNT, bus.OVF,
                        bus.LOWV}, 32'd0);
    end

    // Normal: HV ok 5 cycles after START, 7 ticks. SETTLE begins at edge 7, VALID at 7+104.
    measure(7, 1'b0);
    chk("valid_latency", cyc - t0, 32'd111);
    chk("osc_cycles", osc_cnt, 32'd6);
    chk("norm_count", {28'd0, bus.COUNT}, 32'd7);
    chk("norm_ovf", {31'd0, bus.OVF}, 32'd0);
    chk("norm_lowv", {31'd0, bus.LOWV}, 32'd0);
    ack();
    chk("ack_valid", {31'd0, bus.VALID}, 32'd0);
    chk("ack_busy", {31'd0, bus.BUSY}, 32'd0);

    // Saturation, then a short run clears the flags.
    measure(20, 1'b0);
    chk("sat_count", {28'd0, bus.COUNT}, 32'd15);
    chk("sat_ovf", {31'd0, bus.OVF}, 32'd1);
    ack();
    measure(3, 1'b0);
    chk("post_sat_count", {28'd0, bus.COUNT}, 32'd3);
    chk("post_sat_ovf", {31'd0, bus.OVF}, 32'd0);
    ack();

    // Charge timeout with HV never reported.
    start_run();
    wait_done();
    chk("fault_latency", cyc - t0, 32'd16);
    chk("fault_flag", {31'd0, bus.FAULT}, 32'd1);
    chk("fault_osc", {31'd0, OSCOUT}, 32'd0);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
    chk("fault_start_ignored", {30'd0, bus.FAULT, bus.BUSY}, 32'd2);
    ack();
    chk("fault_ack", {31'd0, bus.FAULT}, 32'd0);

    // Droop mid-gate: 3 extra oscillator cycles, LOWV reported, counting unaffected.
    measure(5, 1'b1);
    chk("droop_osc_cycles", osc_cnt, 32'd9);
    chk("droop_lowv", {31'd0, bus.LOWV}, 32'd1);
    chk("droop_count", {28'd0, bus.COUNT}, 32'd5);
    ack();

    // Abort mid-gate.
    start_run();
    wait_rel(4);
    nCHARGED = 1'b0;
    wait_rel(40);
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
    chk("abort_idle", {30'd0, OSCOUT, bus.BUSY}, 32'd0);
    osc_cnt = 0;
    begin
      int vseen = 0;
      for (int i = 0; i < 150; i++) begin
        @(negedge CLK);
        if (bus.VALID) vseen++;
      end
      chk("abort_no_valid", vseen, 32'd0);
    end

    // Asynchronous reset mid-gate during a droop.
    start_run();
    wait_rel(4);
    nCHARGED = 1'b0;
    wait_rel(15);
    send_ticks(2);
    wait_rel(30);
    nCHARGED = 1'b1;
    wait_rel(34);
    chk("pre_rst_osc", {31'd0, OSCOUT}, 32'd1);
    chk("pre_rst_count", {28'd0, bus.COUNT}, 32'd2);
    #2 nRESET = 1'b0;
    #1;
    chk("rst_osc_immediate", {31'd0, OSCOUT}, 32'd0);
    chk("rst_count", {28'd0, bus.COUNT}, 32'd0);
    repeat (2) @(negedge CLK);
    nRESET = 1'b1;

    // Randomized stretch, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      bus.START = ($urandom_range(7) == 0);
      bus.ABORT = ($urandom_range(299) == 0);
      bus.ACK = ($urandom_range(9) == 0);
      if ($urandom_range(2) == 0) TICK = ~TICK;
      if ($urandom_range(39) == 0) nCHARGED = ~nCHARGED;
    end
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.ACK = 1'b0;
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rad_meas_sequencer.md
# rad_meas_sequencer

Clocked measurement sequencer for the Radboy Geiger-Müller front end. It brings the tube high voltage up, waits for it to settle, and counts tube ticks over a fixed gate window. It then holds the result for the host logic until acknowledged. It owns the HV oscillator enable, so software no longer has to time charge and gate windows by polling.

## Interface
Parameters:
- CNT_W, 6: width of tick count.
- TMR_W, 24: width of internal phase timer. All cycle parameters must be ≤ 2^TMR_W and ≥ 1.
- CHARGE_TIMEOUT, 65535: maximum cycles allowed in CHARGE.
- SETTLE_CYCLES, 1024: exact cycles spent in SETTLE.
- GATE_CYCLES, 1000000: exact cycles spent in GATE.

Ports:
- CLK  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- START  in  1  measurement request, sampled only in IDLE
- ABORT  in  1  return to IDLE from any state, highest priority
- ACK  in  1  result or fault acknowledge, sampled in HOLD/FAULT
- TICK  in  1  asynchronous GM tube pulse
- nCHARGED  in  1  asynchronous HV detect, low = HV ok
- OSCOUT  out  1  HV oscillator enable
- BUSY  out  1  state is CHARGE, SETTLE or GATE
- VALID  out  1  result held (state HOLD)
- FAULT  out  1  charge timeout (state FAULT)
- COUNT  out  CNT_W  tick count of last gate
- OVF  out  1  tick arrived while COUNT saturated
- LOWV  out  1  HV dropped out during last gate

## Operation
- Input conditioning:
  - TICK and nCHARGED each pass through a 2-FF synchroniser, giving TICK_s and nCHARGED_s.
  - A tick event is a rising edge of TICK_s, detected with one extra register.
- OSCOUT = (state ∈ {CHARGE, SETTLE, GATE}) & nCHARGED_s. OSCOUT is combinational from registered signals only. It regulates HV in all three active states.
- States and transitions, evaluated per clock, with ABORT checked first:
  - ABORT=1 in any non-IDLE state → IDLE. VALID and FAULT clear; COUNT, OVF and LOWV are retained.
  - IDLE:
    - START=1 → CHARGE; timer cleared.
  - CHARGE:
    - nCHARGED_s=0 → SETTLE; timer cleared.
    - Otherwise, timer = CHARGE_TIMEOUT−1 → FAULT.
    - Otherwise, timer increments.
  - SETTLE:
    - Timer = SETTLE_CYCLES−1 → GATE. On this transition the timer is cleared and COUNT, OVF and LOWV are cleared.
  - GATE:
    - Each tick event: if COUNT < 2^CNT_W−1, COUNT increments; otherwise OVF sets.
    - Any cycle with nCHARGED_s=1 sets LOWV.
    - Timer = GATE_CYCLES−1 → HOLD. A tick event in that final cycle is still counted.
  - HOLD: VALID=1; COUNT, OVF and LOWV are stable.
    - ACK=1 → IDLE.
  - FAULT: FAULT=1, OSCOUT=0.
    - ACK=1 → IDLE.
- START outside IDLE is ignored and is not queued. START and ACK together in HOLD → IDLE only; START must be held to start a new measurement.
- Tick events outside GATE are discarded.
- COUNT, OVF and LOWV change only in GATE or on the SETTLE→GATE clear.
- Arithmetic rules:
  - COUNT saturates and never wraps.
  - The timer compares with equality against parameter−1 and never wraps within a phase.

## Timing
- Reset state: IDLE, timer 0, synchronisers 0. OSCOUT, BUSY, VALID, FAULT, COUNT, OVF and LOWV all 0.
- Reset is asynchronous. Assertion mid-operation forces OSCOUT=0 immediately, with no clock needed.
- Start latency: START high at edge n → state CHARGE and BUSY=1 after edge n. OSCOUT=1 in that same cycle if nCHARGED_s=1.
- nCHARGED pin to OSCOUT response: 2 clocks (synchroniser).
- TICK pin rising to COUNT increment: 3 clocks. TICK high and low must each last ≥ 2 clocks to be counted.
- Phase durations:
  - CHARGE: ≤ CHARGE_TIMEOUT cycles.
  - SETTLE: exactly SETTLE_CYCLES cycles.
  - GATE: exactly GATE_CYCLES cycles.
- Handshake exits take one cycle:
  - VALID falls in the cycle after ACK is sampled.
  - FAULT falls in the cycle after ACK is sampled.
  - ABORT takes effect in the next cycle.

## Test plan
Bench parameters: CNT_W=4, TMR_W=8, CHARGE_TIMEOUT=16, SETTLE_CYCLES=4, GATE_CYCLES=100.

- Reset:
  - Stimulus: assert nRESET low with TICK toggling, release, no START.
  - Required: all outputs 0 and BUSY=0 for 50 cycles.
- Normal measurement:
  - Stimulus: START pulse; nCHARGED pin falls 5 cycles later; 7 ticks within GATE.
  - Required: OSCOUT high until 2 cycles after the fall. VALID rises exactly 4+100 cycles after SETTLE entry, with COUNT=7, OVF=0, LOWV=0.
  - Then: ACK. Required: VALID=0 and BUSY=0 next cycle.
- Saturation:
  - Stimulus: 20 ticks during GATE.
  - Required: COUNT=15, OVF=1. A following run with 3 ticks gives COUNT=3, OVF=0.
- Charge timeout:
  - Stimulus: nCHARGED held high.
  - Required: FAULT=1 and OSCOUT=0 after 16 CHARGE cycles. START is ignored while in FAULT. ACK → IDLE, FAULT=0.
- Droop:
  - Stimulus: nCHARGED pulses high for 3 cycles mid-GATE.
  - Required: OSCOUT high for 3 cycles, delayed 2 cycles from the pulse. LOWV=1 at HOLD. Tick counting is unaffected.
- ABORT and reset mid-GATE:
  - Stimulus: ABORT mid-GATE.
  - Required: IDLE, OSCOUT=0 and BUSY=0 next cycle; VALID never rises.
  - Stimulus: nRESET low mid-GATE.
  - Required: OSCOUT=0 immediately, COUNT=0.
